imem_loader: RTL
================

# imem_loader

Program loader that writes the instruction memory read by the fetch stage. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word is written into instruction memory at consecutive word addresses, and an XOR checksum is verified at the end. It holds the core in reset (active-low, matching the PC reset) from power-up until a load completes with a good checksum.

## Interface
Parameters:
- DEPTH, 32, instruction memory depth in words
- CNT_W, 6, width of word_count; must hold DEPTH+1

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin a load; sampled only in IDLE
- word_count  in  CNT_W  number of words to load; sampled with start
- byte_valid  in  1  byte_data is valid
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts byte_data this cycle
- mem_we  out  1  instruction memory write strobe, one cycle per word
- mem_addr  out  32  byte address of the write, word-aligned (bits 1:0 = 0)
- mem_wdata  out  32  assembled instruction word
- busy  out  1  load in progress (any state other than IDLE)
- done  out  1  one-cycle pulse at the end of every load attempt
- err  out  1  sticky: checksum mismatch or word_count > DEPTH
- core_rst_n  out  1  active-low reset to the core; 1 only after a good load

## Operation
- States: IDLE, RECV, WRITE, CSUM.
- IDLE:
  - byte_ready=0.
  - On start: latch word_count into cnt, clear word_idx, byte_idx, the XOR accumulator and err, and drive core_rst_n=0.
    - cnt > DEPTH: set err, pulse done next cycle, stay in IDLE, perform no writes.
    - cnt = 0: go to CSUM.
    - Otherwise go to RECV.
- RECV:
  - byte_ready=1. On a byte_valid&byte_ready beat:
    - byte_data goes to word bits [8*byte_idx+7 : 8*byte_idx]; the first byte is bits 7:0.
    - acc ^= byte_data; byte_idx++.
  - After the 4th beat go to WRITE.
- WRITE:
  - byte_ready=0; mem_we=1; mem_addr={word_idx,2'b00}; mem_wdata=assembled word.
  - Then word_idx++ and byte_idx=0.
  - If word_idx was cnt-1, go to CSUM; otherwise go to RECV.
- CSUM:
  - byte_ready=1; accept exactly one byte.
  - Match (byte == acc): core_rst_n=1, err=0.
  - Mismatch: err=1, core_rst_n stays 0.
  - Pulse done; go to IDLE.
- start outside IDLE is ignored. byte_valid in IDLE or WRITE is not consumed (byte_ready=0).
- Words already written before an error or reset are not rolled back.
- mem_addr and mem_wdata hold their last values when mem_we=0.

## Timing
- Reset values: byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, core_rst_n=0; state=IDLE.
- rst mid-load:
  - Next edge forces all reset values and state IDLE.
  - No further mem_we.
  - The next start loads from address 0.
- start sampled at edge N:
  - busy=1 and byte_ready=1 from cycle N+1 (RECV or CSUM).
  - For the cnt > DEPTH case: done=1 and err=1 in cycle N+1, busy stays 0.
- Peak throughput is 5 cycles per word: 4 accept cycles plus 1 WRITE cycle.
- mem_we is asserted the cycle after the 4th byte beat.
- CSUM byte accepted at edge M:
  - done=1 in cycle M+1 only.
  - core_rst_n and err take their final values in M+1 and hold until the next start or rst.
- core_rst_n falls in the cycle after start is accepted. The core stays in reset for the entire load.
- The handshake allows unlimited backpressure; byte_valid gaps stall the FSM in place without losing state.

## Test plan
- Good 2-word load:
  - Stimulus: word_count=2; bytes 13 01 50 00 33 02 21 00, checksum 52.
  - Required response:
    - mem_we at addr 0x0 with 0x00500113.
    - mem_we at addr 0x4 with 0x00210233.
    - One done pulse, err=0, core_rst_n=1.
- Bad checksum: same stream with checksum 53 -> same two writes, done pulse, err=1, core_rst_n=0.
- Backpressure: same good stream with random byte_valid gaps and valid held high through WRITE cycles.
  - Identical writes and result.
  - No byte consumed while byte_ready=0.
  - Exactly 9 beats accepted.
- Boundaries:
  - word_count=0 with checksum 00 -> no mem_we, done, core_rst_n=1.
  - word_count=33 (DEPTH=32) -> done and err in the cycle after start, busy never set, no mem_we.
- Full depth: word_count=32 with an incrementing pattern -> 32 writes, last at addr 0x7C; correct checksum gives core_rst_n=1.
- Reset mid-load:
  - rst after 5 accepted bytes (1 word written) -> all outputs at reset values next cycle and no further mem_we.
  - A subsequent good load then writes starting at addr 0x0.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction memory loader: assembles a little-endian byte stream into 32-bit words,
// writes them at consecutive word addresses and releases the core after a good XOR checksum.
module imem_loader #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] word_count,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             core_rst_n
);

  localparam logic [CNT_W-1:0] DepthC = CNT_W'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRecv, StWrite, StCsum} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] word_idx_q, word_idx_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [7:0]       acc_q, acc_d;
  logic [31:0]      word_q, word_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             core_rst_n_q, core_rst_n_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      acc_q        <= '0;
      word_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      acc_q        <= acc_d;
      word_q       <= word_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      done_q       <= done_d;
      err_q        <= err_d;
      core_rst_n_q <= core_rst_n_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    acc_d        = acc_q;
    word_d       = word_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    done_d       = 1'b0;
    err_d        = err_q;
    core_rst_n_d = core_rst_n_q;
    byte_ready   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d        = word_count;
          word_idx_d   = '0;
          byte_idx_d   = '0;
          acc_d        = '0;
          err_d        = 1'b0;
          core_rst_n_d = 1'b0;
          if (word_count > DepthC) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else if (word_count == '0) begin
            state_d = StCsum;
          end else begin
            state_d = StRecv;
          end
        end
      end
      StRecv: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = byte_data;
          acc_d      = acc_q ^ byte_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // Latch the write beat now so address/data are registered during WRITE.
            addr_d  = {{(30 - CNT_W){1'b0}}, word_idx_q, 2'b00};
            wdata_d = word_d;
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        word_idx_d = word_idx_q + CNT_W'(1);
        byte_idx_d = '0;
        state_d    = (word_idx_q == cnt_q - CNT_W'(1)) ? StCsum : StRecv;
      end
      StCsum: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          done_d  = 1'b1;
          state_d = StIdle;
          if (byte_data == acc_q) begin
            core_rst_n_d = 1'b1;
            err_d        = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    endcase
  end

  assign mem_we     = (state_q == StWrite);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign err        = err_q;
  assign core_rst_n = core_rst_n_q;

endmodule
